// File: rtl/operand_fetch.sv
//==============================================================================
// Module      : operand_fetch
// Description : Streams operand pairs from a dual-read-port data memory to a
//               pair of downstream adders, two words per valid/ready handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module operand_fetch #(
    parameter int WORDSIZE = 16,
    parameter int ADDRSIZE = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] base_addr,
    input  logic [ADDRSIZE:0]   count,
    output logic [ADDRSIZE-1:0] addr0,
    output logic [ADDRSIZE-1:0] addr1,
    input  logic [WORDSIZE-1:0] data0,
    input  logic [WORDSIZE-1:0] data1,
    output logic [WORDSIZE-1:0] r0,
    output logic [WORDSIZE-1:0] r1,
    output logic                valid,
    input  logic                ready,
    output logic                last,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_fetch = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [ADDRSIZE-1:0] c_ptr_one = ADDRSIZE'(1);
    localparam logic [ADDRSIZE-1:0] c_ptr_two = ADDRSIZE'(2);
    localparam logic [ADDRSIZE:0]   c_rem_two = (ADDRSIZE+1)'(2);

    logic [1:0]          r_state;
    logic [ADDRSIZE-1:0] r_ptr;
    logic [ADDRSIZE:0]   r_rem;

    // Read ports follow the pointer in every state; addr1 wraps independently.
    assign addr0 = r_ptr;
    assign addr1 = r_ptr + c_ptr_one;
    assign busy  = (r_state != c_idle);
    assign done  = (r_state == c_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_ptr   <= '0;
            r_rem   <= '0;
            r0      <= '0;
            r1      <= '0;
            valid   <= 1'b0;
            last    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        if (count != '0) begin
                            r_ptr   <= base_addr;
                            r_rem   <= count;
                            r_state <= c_fetch;
                        end else begin
                            r_state <= c_done;
                        end
                    end
                end
                c_fetch: begin
                    // A lone trailing operand is paired with the additive identity.
                    r0      <= data0;
                    r1      <= (r_rem >= c_rem_two) ? data1 : '0;
                    last    <= (r_rem <= c_rem_two);
                    valid   <= 1'b1;
                    r_state <= c_hold;
                end
                c_hold: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (last) begin
                            r_state <= c_done;
                        end else begin
                            r_ptr   <= r_ptr + c_ptr_two;
                            r_rem   <= r_rem - c_rem_two;
                            r_state <= c_fetch;
                        end
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
//==============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch against a pair-list model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_operand_fetch;

    localparam int WORDSIZE = 16;
    localparam int ADDRSIZE = 5;
    localparam int DEPTH    = 1 << ADDRSIZE;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [ADDRSIZE-1:0] base_addr;
    logic [ADDRSIZE:0]   count;
    logic [ADDRSIZE-1:0] addr0;
    logic [ADDRSIZE-1:0] addr1;
    logic [WORDSIZE-1:0] data0;
    logic [WORDSIZE-1:0] data1;
    logic [WORDSIZE-1:0] r0;
    logic [WORDSIZE-1:0] r1;
    logic                valid;
    logic                ready;
    logic                last;
    logic                busy;
    logic                done;

    int n_cmp  = 0;
    int n_fail = 0;
    int last_ptr = 0;

    operand_fetch #(.WORDSIZE(WORDSIZE), .ADDRSIZE(ADDRSIZE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .addr0(addr0), .addr1(addr1), .data0(data0),
        .data1(data1), .r0(r0), .r1(r1), .valid(valid), .ready(ready),
        .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory contents: mem[a] = a + 1
    assign data0 = WORDSIZE'(addr0) + 16'd1;
    assign data1 = WORDSIZE'(addr1) + 16'd1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one run and compare every pair against the list computed from base/n.
    task automatic do_run(input int b, input int n, input int max_stall);
        int np, a0, exp_r0, exp_r1, cyc, stall;
        base_addr = ADDRSIZE'(b);
        count     = (ADDRSIZE+1)'(n);
        start     = 1'b1;
        ready     = 1'($urandom % 2);
        step();
        start = 1'b0;
        if (n == 0) begin
            chk("zero_valid", 32'(valid), 0);
            chk("zero_done", 32'(done), 1);
            chk("zero_busy", 32'(busy), 1);
            step();
            chk("zero_done_end", 32'(done), 0);
            chk("zero_busy_end", 32'(busy), 0);
            chk("zero_addr_held", 32'(addr0), 32'(last_ptr));
            return;
        end
        np = (n + 1) / 2;
        for (int k = 0; k < np; k++) begin
            chk("fetch_valid_low", 32'(valid), 0);
            cyc = 0;
            while (!valid && cyc < 8) begin
                step();
                cyc++;
            end
            chk("valid_latency", 32'(cyc), 1);
            a0     = (b + 2 * k) % DEPTH;
            exp_r0 = a0 + 1;
            exp_r1 = (2 * k + 1 < n) ? ((a0 + 1) % DEPTH) + 1 : 0;
            chk("addr0", 32'(addr0), 32'(a0));
            chk("addr1", 32'(addr1), 32'((a0 + 1) % DEPTH));
            chk("r0", 32'(r0), 32'(exp_r0));
            chk("r1", 32'(r1), 32'(exp_r1));
            chk("last", 32'(last), 32'(k == np - 1));
            stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            for (int s = 0; s < stall; s++) begin
                ready     = 1'b0;
                start     = 1'($urandom % 2);
                base_addr = ADDRSIZE'($urandom);
                count     = (ADDRSIZE+1)'($urandom_range(0, DEPTH));
                step();
                chk("stall_valid", 32'(valid), 1);
                chk("stall_r0", 32'(r0), 32'(exp_r0));
                chk("stall_r1", 32'(r1), 32'(exp_r1));
                chk("stall_last", 32'(last), 32'(k == np - 1));
            end
            ready = 1'b1;
            start = 1'b0;
            step();
            ready = 1'($urandom % 2);
            last_ptr = a0;
        end
        chk("end_valid", 32'(valid), 0);
        chk("end_done", 32'(done), 1);
        chk("end_busy", 32'(busy), 1);
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_addr_held", 32'(addr0), 32'(last_ptr));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; ready = 1'b0;
        base_addr = '0; count = '0;
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_r0", 32'(r0), 0);
        chk("rst_r1", 32'(r1), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr0", 32'(addr0), 0);
        chk("rst_addr1", 32'(addr1), 1);
        step(); step();
        rst_n = 1'b1;
        step();

        do_run(0, 4, 0);     // two full pairs, ready high
        do_run(4, 3, 0);     // odd count, trailing zero
        do_run(30, 4, 0);    // wrap across the top of memory
        do_run(31, 2, 0);    // addr1 wraps while addr0 does not
        do_run(7, 2, 5);     // stalled handshakes with ignored start pulses
        do_run(12, 0, 0);    // empty run
        do_run(0, 32, 2);    // full memory sweep
        for (int i = 0; i < 10; i++)
            do_run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), 4);

        // Reset asserted between edges while a pair is held.
        base_addr = 5'd10; count = 6'd6; start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 8) begin
            step();
            cyc++;
        end
        chk("pre_rst_valid", 32'(valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_r0", 32'(r0), 0);
        chk("async_rst_r1", 32'(r1), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_addr0", 32'(addr0), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        last_ptr = 0;
        step();
        chk("post_rst_done", 32'(done), 0);
        do_run(10, 6, 2);
        do_run(3, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
